// File: rtl/picomips4test.sv
// Board-level top: radix-2 complex FFT butterfly on 8-bit signed data.
// Operands are keyed in on SW[7:0] with SW[8]; results are stepped out on LED.
module picomips4test (
  input  logic       fastclk,
  input  logic [9:0] SW,
  output logic [7:0] LED
);

  typedef enum logic [3:0] {
    CAP_RW, CAP_IW, CAP_RB, CAP_IB, CAP_RA, CAP_IA,
    COMPUTE, SHOW_RY, SHOW_IY, SHOW_RZ, SHOW_IZ
  } state_t;

  logic       rst;
  logic [7:0] din;
  assign rst = SW[9];
  assign din = SW[7:0];

  // Handshake: a press is a one-cycle pulse on the rising edge of the
  // synchronized SW[8]; holding yields one press, release yields none.
  logic sync1_q, sync2_q, prev_q, press;

  always_ff @(posedge fastclk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= SW[8];
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign press = sync2_q & ~prev_q;

  state_t     state_q, state_d;
  logic [7:0] rw_q, iw_q, rb_q, ib_q, ra_q, ia_q;
  logic [7:0] rw_d, iw_d, rb_d, ib_d, ra_d, ia_d;
  logic [7:0] ry_q, iy_q, rz_q, iz_q, led_q;
  logic [7:0] ry_d, iy_d, rz_d, iz_d, led_d;
  logic [7:0] tr, ti;

  // Q1.7 multiply: bits [14:7] of the full product floor-divide by 128.
  function automatic logic [7:0] qmul(input logic signed [7:0] a,
                                      input logic signed [7:0] b);
    logic signed [15:0] p;
    p = a * b;
    return p[14:7];
  endfunction

  assign tr = qmul(rb_q, rw_q) - qmul(ib_q, iw_q);
  assign ti = qmul(rb_q, iw_q) + qmul(ib_q, rw_q);

  always_comb begin
    state_d = state_q;
    rw_d = rw_q; iw_d = iw_q; rb_d = rb_q; ib_d = ib_q; ra_d = ra_q; ia_d = ia_q;
    ry_d = ry_q; iy_d = iy_q; rz_d = rz_q; iz_d = iz_q;
    led_d = led_q;
    case (state_q)
      CAP_RW:  if (press) begin rw_d = din; led_d = din; state_d = CAP_IW; end
      CAP_IW:  if (press) begin iw_d = din; led_d = din; state_d = CAP_RB; end
      CAP_RB:  if (press) begin rb_d = din; led_d = din; state_d = CAP_IB; end
      CAP_IB:  if (press) begin ib_d = din; led_d = din; state_d = CAP_RA; end
      CAP_RA:  if (press) begin ra_d = din; led_d = din; state_d = CAP_IA; end
      CAP_IA:  if (press) begin ia_d = din; led_d = din; state_d = COMPUTE; end
      COMPUTE: begin
        ry_d    = ra_q + tr;
        iy_d    = ia_q + ti;
        rz_d    = ra_q - tr;
        iz_d    = ia_q - ti;
        led_d   = ra_q + tr;
        state_d = SHOW_RY;
      end
      SHOW_RY: if (press) begin led_d = iy_q; state_d = SHOW_IY; end
      SHOW_IY: if (press) begin led_d = rz_q; state_d = SHOW_RZ; end
      SHOW_RZ: if (press) begin led_d = iz_q; state_d = SHOW_IZ; end
      SHOW_IZ: if (press) begin led_d = 8'h00; state_d = CAP_RW; end
      default: begin led_d = 8'h00; state_d = CAP_RW; end
    endcase
  end

  always_ff @(posedge fastclk) begin
    if (rst) begin
      state_q <= CAP_RW;
      rw_q <= '0; iw_q <= '0; rb_q <= '0; ib_q <= '0; ra_q <= '0; ia_q <= '0;
      ry_q <= '0; iy_q <= '0; rz_q <= '0; iz_q <= '0;
      led_q <= '0;
    end else begin
      state_q <= state_d;
      rw_q <= rw_d; iw_q <= iw_d; rb_q <= rb_d; ib_q <= ib_d; ra_q <= ra_d; ia_q <= ia_d;
      ry_q <= ry_d; iy_q <= iy_d; rz_q <= rz_d; iz_q <= iz_d;
      led_q <= led_d;
    end
  end

  assign LED = led_q;

endmodule

// File: tb/tb_picomips4test.sv
// Bench for picomips4test: randomized operand entry against a butterfly
// reference model, LED checked from an expected-value queue.
module tb_picomips4test;

  logic       fastclk;
  logic [9:0] sw;
  logic [7:0] led;

  picomips4test dut (
    .fastclk (fastclk),
    .SW      (sw),
    .LED     (led)
  );

  // clock / reset block
  initial fastclk = 1'b0;
  always #5 fastclk = ~fastclk;

  // scoreboard
  logic [7:0] exp_q[$];
  int         due_q[$];
  string      name_q[$];
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;

  always @(negedge fastclk) begin
    cyc = cyc + 1;
    while (exp_q.size() > 0 && due_q[0] <= cyc) begin
      logic [7:0] e;
      string      nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      void'(due_q.pop_front());
      n_tests = n_tests + 1;
      if (led !== e) begin
        n_fail = n_fail + 1;
        $display("FAIL %s: LED=%h expected %h (cycle %0d)", nm, led, e, cyc);
      end
    end
  end

  task automatic push_exp(input logic [7:0] v, input string nm);
    exp_q.push_back(v);
    due_q.push_back(cyc + 1);
    name_q.push_back(nm);
  endtask

  // reference model: operand list, result list, phase of the operator dialogue
  logic [7:0] ops[6];
  logic [7:0] res[4];
  logic [7:0] mled;
  int         phase;

  function automatic int sx(input logic [7:0] v);
    return int'($signed(v));
  endfunction

  task automatic model_compute();
    int rw, iw, rb, ib, ra, ia, tr, ti;
    rw = sx(ops[0]); iw = sx(ops[1]); rb = sx(ops[2]);
    ib = sx(ops[3]); ra = sx(ops[4]); ia = sx(ops[5]);
    tr = ((rb * rw) >>> 7) - ((ib * iw) >>> 7);
    ti = ((rb * iw) >>> 7) + ((ib * rw) >>> 7);
    res[0] = 8'(ra + tr);
    res[1] = 8'(ia + ti);
    res[2] = 8'(ra - tr);
    res[3] = 8'(ia - ti);
  endtask

  task automatic model_press(input logic [7:0] v);
    if (phase < 6) begin
      ops[phase] = v;
      mled = v;
      if (phase == 5) begin
        model_compute();
        mled = res[0];
      end
      phase = phase + 1;
    end else if (phase < 9) begin
      mled = res[phase - 5];
      phase = phase + 1;
    end else begin
      mled = 8'h00;
      phase = 0;
    end
  endtask

  // driver tasks
  task automatic do_press(input logic [7:0] v);
    @(posedge fastclk); #1;
    sw[7:0] = v;
    sw[8]   = 1'b1;
    repeat (8) @(posedge fastclk);
    #1;
    sw[8]   = 1'b0;
    sw[7:0] = 8'($urandom);
    repeat (4) @(posedge fastclk);
    #1;
    model_press(v);
    push_exp(mled, $sformatf("press_phase%0d", phase));
  endtask

  task automatic do_reset(input logic hold_btn);
    @(posedge fastclk); #1;
    sw[9] = 1'b1;
    sw[8] = hold_btn;
    repeat (10) @(posedge fastclk);
    #1;
    phase = 0;
    mled  = 8'h00;
    push_exp(8'h00, "reset_led");
    sw[9] = 1'b0;
    if (hold_btn) begin
      repeat (6) @(posedge fastclk);
      #1;
      sw[7:0] = 8'h55;
      repeat (3) @(posedge fastclk);
      #1;
      push_exp(8'h00, "held_btn_no_capture");
      sw[8] = 1'b0;
    end
    repeat (4) @(posedge fastclk);
  endtask

  task automatic full_round(input logic [7:0] a0, a1, a2, a3, a4, a5);
    do_press(a0); do_press(a1); do_press(a2);
    do_press(a3); do_press(a4); do_press(a5);
    repeat (4) do_press(8'($urandom));
  endtask

  initial begin
    sw    = 10'h000;
    phase = 0;
    mled  = 8'h00;
    repeat (2) @(posedge fastclk);

    do_reset(1'b1);
    full_round(8'h40, 8'hC0, 8'h0A, 8'h04, 8'h01, 8'h08);
    // after returning to CAP_RW, the next press is a fresh Rw capture
    do_press(8'h08);
    do_press(8'h11);
    do_press(8'h03); do_press(8'hFD); do_press(8'h20); do_press(8'hE0);
    repeat (4) do_press(8'($urandom));

    full_round(8'h7F, 8'h00, 8'h80, 8'h00, 8'h7F, 8'h00);
    full_round(8'h40, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00);
    full_round(8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80);

    // abort mid-entry, then a fresh set of operands
    do_press(8'h12); do_press(8'h34); do_press(8'h56);
    do_reset(1'b0);
    full_round(8'h9C, 8'h27, 8'hF1, 8'h6A, 8'hC3, 8'h05);

    for (int r = 0; r < 8; r++) begin
      full_round(8'($urandom), 8'($urandom), 8'($urandom),
                 8'($urandom), 8'($urandom), 8'($urandom));
    end

    repeat (5) @(posedge fastclk);
    if (exp_q.size() != 0) begin
      n_tests = n_tests + 1;
      n_fail  = n_fail + 1;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/picomips4test.md
Name: picomips4test

Overview:
- Board-level top for a single radix-2 complex FFT butterfly on 8-bit signed fixed-point data.
- Six operands are entered one at a time on switches SW[7:0], each handshaken by a press of SW[8].
- The block computes Y = A + B·W and Z = A − B·W.
- The four result words are stepped out on LED[7:0] by further presses.

Parameters:
- None; all widths are fixed (8-bit data, Q1.7 twiddle format).

Ports:
- fastclk  input  1  System clock; all logic rises on it.
- SW  input  10  Switch bank:
  - SW[9] is reset: synchronous, active-high; sampled on fastclk.
  - SW[8] is the step/enter button, active-high, asynchronous to fastclk.
  - SW[7:0] is the data operand.
- LED  output  8  Display register. Its content depends on state (see Behaviour).

Behaviour:
- Reset (SW[9]=1 at a fastclk edge):
  - FSM goes to CAP_RW.
  - All operand and result registers are cleared to 0.
  - LED=0.
  - Button synchronizer flops are set to 1, so a button held through reset is not counted as a press.
- Button handling:
  - SW[8] passes through a 2-flop synchronizer, then a rising-edge detector.
  - A "press" is a single-cycle pulse, asserted 2–3 fastclk cycles after SW[8] rises.
  - Holding SW[8] yields exactly one press. A release produces nothing.
- Data sampling:
  - On the press pulse cycle, SW[7:0] is captured directly, with no synchronizer.
  - The operator must keep data stable from the SW[8] rising edge until at least 4 cycles later.
- FSM input states, in order. Each state captures SW[7:0] into its register on a press, then advances:
  - CAP_RW → Rw (twiddle real, signed Q1.7, 0x40 = +0.5)
  - CAP_IW → Iw (twiddle imaginary, Q1.7)
  - CAP_RB → Rb (signed 8-bit integer)
  - CAP_IB → Ib (signed 8-bit integer)
  - CAP_RA → Ra (signed 8-bit integer)
  - CAP_IA → Ia (signed 8-bit integer)
- LED during input states: shows the most recently captured operand, or 0 if none since reset.
- COMPUTE (entered after the Ia capture; at most 4 cycles; button presses are ignored here):
  - Products: signed 8×8 → 16-bit, scaled by arithmetic right shift 7 (bits [14:7]), i.e. truncation toward −∞:
    - P1 = Rb·Rw
    - P2 = Ib·Iw
    - P3 = Rb·Iw
    - P4 = Ib·Rw
  - Intermediate terms:
    - Tr = P1 − P2
    - Ti = P3 + P4
  - Results:
    - Ry = Ra + Tr
    - Iy = Ia + Ti
    - Rz = Ra − Tr
    - Iz = Ia − Ti
  - All adds and subtracts are 8-bit two's complement, wrap modulo 256, no saturation.
  - Results are registered. The FSM then enters SHOW_RY with LED=Ry.
- Output states:
  - Each press advances SHOW_RY → SHOW_IY → SHOW_RZ → SHOW_IZ.
  - LED shows the corresponding result, updated the cycle after the press.
- Press in SHOW_IZ:
  - Goes to CAP_RW with LED=0.
  - Operands and results are retained until overwritten.
  - That press is not a capture; the next press captures a new Rw.
- Reset during any state, including COMPUTE: immediately returns to the reset state; no partial results are shown.
- Reset and press in the same cycle: reset wins.

Test Plan:
- Reset for 10 cycles with SW[8]=1 held, then release reset → LED=0, state CAP_RW, and no capture until SW[8] falls and rises again.
- Enter the sequence 0x40, 0xC0, 0x0A, 0x04, 0x01, 0x08, presenting each value at or before its press and changing it 5 cycles after → LED=0x08 (Ry=8) within 4 cycles of the 6th capture. Next presses → LED 0x05 (Iy), 0xFA (Rz=−6), 0x0B (Iz=11).
- Press after Iz → LED=0. The next press with SW=0x08 → Rw=0x08 captured, LED=0x08. The subsequent press captures Iw.
- Rw=0x7F, Iw=0x00, Rb=0x80, Ib=0, Ra=0x7F, Ia=0 → P1 = −128·127>>7 = −127. Required results: Ry=0x00, Iy=0x00, Rz=0xFE (wraps), Iz=0x00.
- Odd product: Rw=0x40, Iw=0, Rb=0xFF (−1), Ib=0, Ra=0, Ia=0 → P1=−1 (floor). Required results: Ry=0xFF, Rz=0x01.
- Assert reset mid-entry after 3 captures → LED=0 and state CAP_RW. Six fresh captures then give results based only on the new operands.
